// File: rtl/pattern_gen_pkg.sv
// Shared encodings for the programmable serial pattern generator.
package pattern_gen_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_REPEAT  = 1'b1;

endpackage

// File: rtl/pattern_gen.sv
// Programmable serial pattern generator: shifts a latched pattern out LSB-first,
// one-shot or repeating, with busy/done/wrap status for a controlling FSM.
//
// state | meaning
// IDLE  | outputs quiet, waiting for start_i (stop_i blocks a start)
// RUN   | presenting shadow[idx] each cycle; wrap_o marks the last bit of a period
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter  int PAT_W = 16,
  localparam int LEN_W = $clog2(PAT_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             mode_q;
  logic [LEN_W-1:0] idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      idx     <= '0;
      out_o   <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_o   <= 1'b0;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          wrap_o  <= 1'b0;
          if (start_i && !stop_i) begin
            pat_q   <= pattern_i;
            len_q   <= len_i;
            mode_q  <= mode_i;
            out_o   <= pattern_i[0];
            valid_o <= 1'b1;
            busy_o  <= 1'b1;
            wrap_o  <= (len_i == '0);
            idx     <= (len_i == '0) ? '0 : LEN_W'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          done_o <= 1'b0;
          // wrap_o high means the bit now on out_o closes the period
          if (stop_i || (wrap_o && mode_q == MODE_ONESHOT)) begin
            state   <= IDLE;
            idx     <= '0;
            out_o   <= 1'b0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            wrap_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            out_o  <= pat_q[idx];
            wrap_o <= (idx == len_q);
            idx    <= (idx == len_q) ? '0 : idx + LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: stimulus pushes the expected output vector
// {out,valid,busy,done,wrap}; a monitor pops and compares after every edge.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, mode;
  logic [3:0]  len;
  logic [15:0] pattern;
  logic        out, valid, busy, done, wrap;

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] DN = 5'b00010;

  pattern_gen #(.PAT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode),
    .len_i(len), .pattern_i(pattern), .out_o(out), .valid_o(valid),
    .busy_o(busy), .done_o(done), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got {out,valid,busy,done,wrap}=%b expected %b", tag, $time, act, exp_v);
    end
  endtask

  task automatic cyc(input logic st, input logic sp, input logic md, input logic [3:0] ln,
                     input logic [15:0] pt, input logic [4:0] ev, input string tag);
    @(negedge clk);
    start   = st;
    stop    = sp;
    mode    = md;
    len     = ln;
    pattern = pt;
    sb.push_back('{tag: tag, v: ev});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, {out, valid, busy, done, wrap}, e.v);
      end else begin
        check("unexpected", {out, valid, busy, done, wrap}, Z);
      end
    end
  end

  initial begin : stim
    logic       b, w;
    logic [7:0] bits_b;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; len = '0; pattern = '0;
    #2;
    check("reset", {out, valid, busy, done, wrap}, Z);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 16'h0000, Z, "post_reset");

    // repeat 4'b1010, len 3; start pulse and pattern change mid-run are ignored
    for (int i = 0; i < 12; i++) begin
      b = (i % 2) == 1;
      w = (i % 4) == 3;
      cyc((i == 0) || (i == 5), 0, 1, (i == 7) ? 4'd0 : 4'd3,
          (i == 6) ? 16'hFFFF : 16'h000A, {b, 3'b110, w}, "rep4");
    end
    cyc(0, 1, 1, 3, 16'h000A, DN, "rep4_stop");
    cyc(0, 0, 1, 3, 16'h000A, Z, "rep4_idle");

    // one-shot 16'h00B5, len 7 -> 1,0,1,0,1,1,0,1
    bits_b = 8'hB5;
    for (int i = 0; i < 8; i++)
      cyc(i == 0, 0, 0, 7, 16'h00B5, {bits_b[i], 3'b110, i == 7}, "os8");
    cyc(0, 0, 0, 7, 16'h00B5, DN, "os8_done");
    cyc(0, 0, 0, 7, 16'h00B5, Z, "os8_idle");

    // len 0 repeat: constant 1 with wrap every cycle, then stop
    for (int i = 0; i < 5; i++)
      cyc(i == 0, 0, 1, 0, 16'h0001, 5'b11101, "len0");
    cyc(0, 1, 1, 0, 16'h0001, DN, "len0_stop");
    cyc(0, 0, 1, 0, 16'h0001, Z, "len0_idle");

    // start and stop together in IDLE
    cyc(1, 1, 0, 2, 16'h0007, Z, "start_stop");
    cyc(1, 1, 1, 2, 16'h0007, Z, "start_stop");
    cyc(0, 0, 0, 2, 16'h0007, Z, "start_stop_idle");

    // async reset mid-burst, then a fresh pattern from bit 0
    for (int i = 0; i < 3; i++)
      cyc(i == 0, 0, 0, 7, 16'h00FF, 5'b11100, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", {out, valid, busy, done, wrap}, Z);
    cyc(0, 0, 0, 7, 16'h00FF, Z, "in_rst");
    rst = 1'b0;
    cyc(1, 0, 0, 2, 16'h0006, 5'b01100, "post_rst");
    cyc(0, 0, 0, 2, 16'h0006, 5'b11100, "post_rst");
    cyc(0, 0, 0, 2, 16'h0006, 5'b11101, "post_rst");
    cyc(0, 0, 0, 2, 16'h0006, DN, "post_rst_done");
    cyc(0, 0, 0, 2, 16'h0006, Z, "post_rst_idle");

    // one-shot len 2, start held: 3 valid cycles, 1-cycle gap with done
    for (int i = 0; i < 12; i++) begin
      case (i % 4)
        0: cyc(1, 0, 0, 2, 16'h0005, 5'b11100, "held");
        1: cyc(1, 0, 0, 2, 16'h0005, 5'b01100, "held");
        2: cyc(1, 0, 0, 2, 16'h0005, 5'b11101, "held");
        default: cyc(1, 0, 0, 2, 16'h0005, DN, "held_gap");
      endcase
    end
    cyc(0, 0, 0, 2, 16'h0005, Z, "held_idle");

    // full-length one-shot, len 15
    for (int i = 0; i < 16; i++) begin
      b = (i == 0) || (i == 15);
      cyc(i == 0, 0, 0, 15, 16'h8001, {b, 3'b110, i == 15}, "len15");
    end
    cyc(0, 0, 0, 15, 16'h8001, DN, "len15_done");
    cyc(0, 0, 0, 15, 16'h8001, Z, "len15_idle");

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Programmable serial pattern generator in the state-machine group. It replaces the fixed 4-state alternating-output machine with a parametrised engine. A PAT_W-bit pattern and a length are loaded on a start request, then shifted out LSB-first, one bit per clock, in one-shot or repeat mode. The block provides start/stop control and busy/done/wrap status for a controlling FSM or test harness.

## Interface
- PAT_W, 16: maximum pattern length in bits; power of two, ≥ 2.
- LEN_W, $clog2(PAT_W): width of the length field (derived, not overridden).
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; honoured only in IDLE.
- stop_i  in  1  abort request; honoured in RUN; wins over start_i in IDLE.
- mode_i  in  1  0 = one-shot, 1 = repeat; latched at start.
- len_i  in  LEN_W  pattern length minus 1 (0 → 1 bit, PAT_W-1 → PAT_W bits); latched at start.
- pattern_i  in  PAT_W  pattern bits; bit 0 is emitted first; latched at start.
- out_o  out  1  serial pattern bit, registered.
- valid_o  out  1  out_o carries a pattern bit.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse on return to IDLE (normal end or abort).
- wrap_o  out  1  one-cycle pulse concurrent with the last bit of each period.

## Operation
- States: IDLE, RUN.
- Registers: shadow pattern (PAT_W), shadow len (LEN_W), shadow mode (1), bit index idx (LEN_W).
- Reset (async, rst_i = 1) forces the following:
  - state = IDLE, idx = 0, shadows = 0.
  - out_o = 0, valid_o = 0, busy_o = 0, done_o = 0, wrap_o = 0.
- IDLE, start_i = 1 and stop_i = 0:
  - latch pattern_i, len_i and mode_i into the shadows.
  - out_o ← pattern_i[0], valid_o ← 1, busy_o ← 1.
  - idx ← 1 mod (len+1); state ← RUN.
  - if len_i = 0, wrap_o ← 1 in the same cycle.
- RUN, each clock without stop:
  - out_o ← shadow[idx], valid_o stays 1.
  - wrap_o ← 1 when the bit being presented is index len.
  - idx advances modulo len+1.
- End of period (the last bit has been presented):
  - repeat mode: bit 0 follows immediately, with no gap.
  - one-shot mode: next edge sets state ← IDLE, valid_o ← 0, out_o ← 0, busy_o ← 0, done_o ← 1.
- RUN, stop_i = 1: next edge sets state ← IDLE, out_o ← 0, valid_o ← 0, busy_o ← 0, done_o ← 1, wrap_o ← 0. The bit in flight is abandoned.
- start_i in RUN is ignored. Input changes in RUN have no effect (shadows hold).
- IDLE, start_i and stop_i both high: stay IDLE, no done_o.
- A start_i accepted in the done_o cycle (state already IDLE) restarts normally. The minimum gap between one-shot bursts is 1 cycle.
- Reset mid-RUN aborts immediately, with no done_o pulse.

## Timing
- Start latency: the first bit appears on out_o the cycle after the edge that samples start_i.
- One-shot burst: valid_o is high for exactly len+1 cycles. done_o follows in the next cycle.
- Repeat: period is len+1 cycles. wrap_o has one pulse per period, aligned with the bit at index len.
- Stop latency: valid_o falls one edge after stop_i is sampled.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package pattern_gen_pkg holds:
  - state encoding localparams (IDLE = 1'b0, RUN = 1'b1).
  - MODE_ONESHOT / MODE_REPEAT constants.
- Single module, no sub-module. Bit selection is an idx mux on the shadow pattern; a wrapping LEN_W counter inline is sufficient.

## Test plan
- PAT_W = 4, pattern 4'b1010, len 3, repeat → out_o = 0,1,0,1,0,1… from cycle 1. wrap_o pulses every 4th cycle. done_o never pulses.
- PAT_W = 16, pattern 16'h00B5, len 7, one-shot → out_o = 1,0,1,0,1,1,0,1. valid_o is high for 8 cycles, then done_o pulses for 1 cycle and busy_o falls.
- len 0, pattern bit0 = 1, repeat → out_o is constant 1, wrap_o high every cycle. A stop after 5 cycles → valid_o low next cycle and done_o pulses once.
- start_i and stop_i high together in IDLE → no state change, all outputs stay 0. start_i pulsed mid-RUN → sequence unaffected.
- rst_i asserted asynchronously mid-burst (between edges) → all outputs 0 immediately, no done_o. The next start after release runs the new pattern from bit 0.
- One-shot, len 2, start_i held high continuously → bursts of 3 valid cycles separated by 1 cycle with valid_o low, done_o pulsing in each gap cycle.
